ikascc_period_sequencer: RTL and testbench

- Time-multiplexed scheduler for the SCC channel period counters: one shared decrement datapath is swept round-robin across CH channels.
- Holds per-channel period registers and count state. Emits per-channel waveform-address advance ticks and the current 5-bit waveform RAM addresses.
- Sits between the bus register file (period writes, channel enables) and the waveform RAM read path.
- All state advances only on cycles where i_MCLK_PCEN_n is low.

---
 rtl/ikascc_seq_pkg.sv | 23 ++
 rtl/ikascc_seq_slot_ctr.sv | 37 +++
 rtl/ikascc_period_sequencer.sv | 134 +++++++++++++
 tb/tb_ikascc_period_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ikascc_seq_pkg.sv
// Shared types and constants for the SCC period sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: default channel count / period width / waveform address width,
// slot/period/address typedefs and the SCC test-register period masks.
package ikascc_seq_pkg;

  localparam int SCC_CH = 5;
  localparam int SCC_PW = 12;
  localparam int SCC_AW = 5;

  // Slot index is 3 bits wide so up to 8 channels can share the datapath.
  typedef logic [2:0]        slot_t;
  typedef logic [SCC_PW-1:0] period_t;
  typedef logic [SCC_AW-1:0] waddr_t;

  // Test-register masks: the SCC test bits shorten the effective period by
  // ignoring the upper counter/period bits.
  localparam period_t MASK4 = 12'h00F;
  localparam period_t MASK8 = 12'h0FF;

endpackage

// File: rtl/ikascc_seq_slot_ctr.sv
// Round-robin modulo-CH slot counter selecting which channel the shared
// decrement datapath services. Latency: slot advances one step per enabled
// clock. Backpressure: none; i_EN low simply freezes the slot.
//
// Ports:
//   i_EMUCLK  clock
//   i_RST     asynchronous reset, active-high (slot -> 0)
//   i_EN      advance enable (one step per enabled clock)
//   o_SLOT    current slot index, wraps CH-1 -> 0
module ikascc_seq_slot_ctr
  import ikascc_seq_pkg::*;
#(
  parameter int CH = SCC_CH
)
(
  input  logic  i_EMUCLK,
  input  logic  i_RST,
  input  logic  i_EN,
  output slot_t o_SLOT
);

  localparam slot_t LAST_SLOT = slot_t'(CH - 1);

  slot_t slot_q;

  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      slot_q <= '0;
    end else if (i_EN) begin
      if (slot_q == LAST_SLOT) slot_q <= '0;
      else                     slot_q <= slot_q + 3'd1;
    end
  end

  assign o_SLOT = slot_q;

endmodule

// File: rtl/ikascc_period_sequencer.sv
// Time-multiplexed SCC period counter scheduler: one decrement datapath swept
// round-robin over CH channels, producing waveform-address advance ticks.
// Latency: o_TICK / o_WADDR update on the enabled clock that services the
// channel. Backpressure: none; i_MCLK_PCEN_n high freezes all state.
//
// Optional build macro: IKASCC_PERIOD_SEQ_TEST_EN adds i_TEST period masks.
//
// Ports:
//   i_EMUCLK       clock (only clock)
//   i_RST          asynchronous reset, active-high
//   i_MCLK_PCEN_n  master clock-enable, active-low
//   i_PRD_WR       period write strobe
//   i_PRD_CH       write target channel (values >= CH ignored)
//   i_PRD_D        period value
//   i_RST_ON_WR    write also reloads counter and clears address
//   i_CH_EN        per-channel run enable
//   i_TEST         (macro only) [1]: 4-bit period, else [0]: 8-bit period
//   o_SLOT         channel serviced this enabled cycle
//   o_TICK         one-enabled-interval advance pulse per channel
//   o_WADDR        flattened addresses, channel c at [c*AW +: AW]
module ikascc_period_sequencer
  import ikascc_seq_pkg::*;
#(
  parameter int CH = SCC_CH,   // 2..8
  parameter int PW = SCC_PW,
  parameter int AW = SCC_AW
)
(
  input  logic             i_EMUCLK,
  input  logic             i_RST,
  input  logic             i_MCLK_PCEN_n,
  input  logic             i_PRD_WR,
  input  logic [2:0]       i_PRD_CH,
  input  logic [PW-1:0]    i_PRD_D,
  input  logic             i_RST_ON_WR,
  input  logic [CH-1:0]    i_CH_EN,
`ifdef IKASCC_PERIOD_SEQ_TEST_EN
  input  logic [1:0]       i_TEST,
`endif
  output logic [2:0]       o_SLOT,
  output logic [CH-1:0]    o_TICK,
  output logic [CH*AW-1:0] o_WADDR
);

  logic          en;
  slot_t         slot;
  logic [PW-1:0] prd_mask;
  logic [CH-1:0] tick_nxt;

  assign en = ~i_MCLK_PCEN_n;

  ikascc_seq_slot_ctr #(
    .CH (CH)
  ) u_slot_ctr (
    .i_EMUCLK (i_EMUCLK),
    .i_RST    (i_RST),
    .i_EN     (en),
    .o_SLOT   (slot)
  );

  assign o_SLOT = slot;

  // Period mask applied to both the reload value and the zero-compare /
  // decrement, never to the stored period register.
`ifdef IKASCC_PERIOD_SEQ_TEST_EN
  always_comb begin
    prd_mask = '1;
    if (i_TEST[1])      prd_mask = PW'(MASK4);
    else if (i_TEST[0]) prd_mask = PW'(MASK8);
  end
`else
  assign prd_mask = '1;
`endif

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [PW-1:0] prd_q;
    logic [PW-1:0] cnt_q;
    logic [AW-1:0] addr_q;
    logic [PW-1:0] eff_cnt;
    logic [PW-1:0] eff_prd;
    logic          svc;
    logic          wr;
    logic          wr_rst;
    logic          hit;

    assign eff_cnt = cnt_q & prd_mask;
    assign eff_prd = prd_q & prd_mask;

    // Channel indices >= CH never match any generated channel, so such
    // writes fall through with no effect.
    assign svc    = en & (slot == slot_t'(c)) & i_CH_EN[c];
    assign wr     = en & i_PRD_WR & (i_PRD_CH == 3'(c));
    assign wr_rst = wr & i_RST_ON_WR;
    assign hit    = svc & (eff_cnt == '0);

    // A resetting write overrides the service in the same cycle, so the
    // reload (and its tick) is dropped.
    assign tick_nxt[c] = hit & ~wr_rst;

    always_ff @(posedge i_EMUCLK or posedge i_RST) begin
      if (i_RST) begin
        prd_q  <= '0;
        cnt_q  <= '1;
        addr_q <= '0;
      end else if (en) begin
        if (wr) prd_q <= i_PRD_D;

        if (wr_rst) begin
          cnt_q  <= i_PRD_D;
          addr_q <= '0;
        end else if (svc) begin
          if (hit) begin
            // prd_q here is the pre-write value: a non-resetting write in
            // this same cycle only takes effect at the following reload.
            cnt_q  <= eff_prd;
            addr_q <= addr_q + AW'(1);
          end else begin
            cnt_q  <= eff_cnt - PW'(1);
          end
        end
      end
    end

    assign o_WADDR[c*AW +: AW] = addr_q;
  end

  // Registered tick: at most one channel is serviced per enabled cycle, so
  // loading the whole vector keeps it one-hot and clears stale bits.
  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST)   o_TICK <= '0;
    else if (en) o_TICK <= tick_nxt;
  end

endmodule

// File: tb/tb_ikascc_period_sequencer.sv
module tb_ikascc_period_sequencer;

  localparam int CH = 5;
  localparam int PW = 12;
  localparam int AW = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             pcen_n;
  logic             prd_wr;
  logic [2:0]       prd_ch;
  logic [PW-1:0]    prd_d;
  logic             rst_on_wr;
  logic [CH-1:0]    ch_en;
`ifdef IKASCC_PERIOD_SEQ_TEST_EN
  logic [1:0]       test;
`endif
  logic [2:0]       slot;
  logic [CH-1:0]    tick;
  logic [CH*AW-1:0] waddr;

  ikascc_period_sequencer #(.CH(CH), .PW(PW), .AW(AW)) dut (
    .i_EMUCLK      (clk),
    .i_RST         (rst),
    .i_MCLK_PCEN_n (pcen_n),
    .i_PRD_WR      (prd_wr),
    .i_PRD_CH      (prd_ch),
    .i_PRD_D       (prd_d),
    .i_RST_ON_WR   (rst_on_wr),
    .i_CH_EN       (ch_en),
`ifdef IKASCC_PERIOD_SEQ_TEST_EN
    .i_TEST        (test),
`endif
    .o_SLOT        (slot),
    .o_TICK        (tick),
    .o_WADDR       (waddr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Enabled-edge counter and per-channel tick bookkeeping.
  int   ecnt = 0;
  int   last_tick [CH];
  int   tick_int  [CH];
  logic tick_seen [CH];

  typedef struct {
    int ch;
    int intv;
    int addr;   // -1: address not checked
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic pcen_n;
    int   slot;
  } vec_t;
  vec_t tbl [20];
  vec_t vq[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int addr_of(input int c);
    return int'(waddr[c*AW +: AW]);
  endfunction

  // One clock; inputs are changed and outputs sampled 1 time unit after
  // the rising edge.
  task automatic step();
    logic was_en;
    was_en = !pcen_n;
    @(posedge clk);
    #1;
    if (was_en) begin
      ecnt++;
      for (int c = 0; c < CH; c++) begin
        if (tick[c]) begin
          tick_int[c]  = ecnt - last_tick[c];
          last_tick[c] = ecnt;
          tick_seen[c] = 1'b1;
        end
      end
    end
    chk("tick_onehot", int'($countones(tick) <= 1), 1);
  endtask

  task automatic wait_tick(input int c, input int budget);
    tick_seen[c] = 1'b0;
    for (int i = 0; i < budget && !tick_seen[c]; i++) step();
    chk("tick_arrived", int'(tick_seen[c]), 1);
  endtask

  task automatic expect_tick(input int budget);
    exp_t e;
    e = sb.pop_front();
    wait_tick(e.ch, budget);
    chk($sformatf("ch%0d_interval", e.ch), tick_int[e.ch], e.intv);
    if (e.addr >= 0) chk($sformatf("ch%0d_addr", e.ch), addr_of(e.ch), e.addr);
  endtask

  task automatic wr(input int c, input int d, input logic r);
    prd_wr    = 1'b1;
    prd_ch    = 3'(c);
    prd_d     = PW'(d);
    rst_on_wr = r;
    step();
    prd_wr    = 1'b0;
    rst_on_wr = 1'b0;
  endtask

  initial begin
    vec_t v;
    int   a4;
    int   s0;

    for (int c = 0; c < CH; c++) begin
      last_tick[c] = 0;
      tick_int[c]  = 0;
      tick_seen[c] = 1'b0;
    end

    // Slot sequence after each edge: ten enabled, eight held, two enabled.
    for (int i = 0; i < 10; i++) tbl[i] = '{1'b0, (i + 1) % CH};
    for (int i = 10; i < 18; i++) tbl[i] = '{1'b1, 0};
    tbl[18] = '{1'b0, 1};
    tbl[19] = '{1'b0, 2};

    rst       = 1'b1;
    pcen_n    = 1'b0;
    prd_wr    = 1'b0;
    prd_ch    = '0;
    prd_d     = '0;
    rst_on_wr = 1'b0;
    ch_en     = '1;
`ifdef IKASCC_PERIOD_SEQ_TEST_EN
    test      = 2'b00;
`endif
    #12;
    chk("reset_slot",  int'(slot), 0);
    chk("reset_tick",  int'(tick), 0);
    chk("reset_waddr", int'(waddr), 0);
    rst = 1'b0;

    // Free-running slot, clock-enable hold, no ticks and zero addresses.
    for (int i = 0; i < 20; i++) begin
      pcen_n = tbl[i].pcen_n;
      vq.push_back(tbl[i]);
      step();
      v = vq.pop_front();
      chk($sformatf("tbl%0d_slot", i), int'(slot), v.slot);
      chk($sformatf("tbl%0d_tick", i), int'(tick), 0);
      chk($sformatf("tbl%0d_waddr", i), int'(waddr), 0);
    end
    pcen_n = 1'b0;

    // ch2 period 3: tick every 20 enabled cycles, address wraps after 32.
    wr(2, 3, 1'b1);
    wait_tick(2, 60);
    chk("ch2_first_addr", addr_of(2), 1);
    for (int k = 2; k <= 33; k++) sb.push_back('{2, 20, k % 32});
    for (int k = 2; k <= 33; k++) expect_tick(60);

    // ch0 period 0 and ch1 period 1: every 5 and every 10 enabled cycles.
    wr(0, 0, 1'b1);
    wr(1, 1, 1'b1);
    wait_tick(0, 30);
    for (int k = 0; k < 3; k++) sb.push_back('{0, 5, -1});
    for (int k = 0; k < 3; k++) expect_tick(30);

    // Clock-enable held high: slot and the live tick pulse must hold.
    s0 = int'(slot);
    pcen_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("hold_slot", int'(slot), s0);
      chk("hold_tick0", int'(tick[0]), 1);
    end
    pcen_n = 1'b0;

    wait_tick(1, 30);
    for (int k = 0; k < 2; k++) sb.push_back('{1, 10, -1});
    for (int k = 0; k < 2; k++) expect_tick(30);

    // ch3 period 4, then period 9 without reload: 25 then 50, 50.
    wr(3, 4, 1'b1);
    wait_tick(3, 60);
    chk("ch3_first_addr", addr_of(3), 1);
    repeat (7) step();
    wr(3, 9, 1'b0);
    sb.push_back('{3, 25, 2});
    sb.push_back('{3, 50, 3});
    sb.push_back('{3, 50, 4});
    for (int k = 0; k < 3; k++) expect_tick(80);

    // ch4 period 5 (30 cycles) frozen for 30 enabled cycles mid-count:
    // the interval stretches to exactly 60 and the address stays put.
    wr(4, 5, 1'b1);
    wait_tick(4, 80);
    chk("ch4_first_addr", addr_of(4), 1);
    a4 = 1;
    repeat (12) step();
    ch_en[4] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      chk("ch4_frozen_tick", int'(tick[4]), 0);
      chk("ch4_frozen_addr", addr_of(4), a4);
    end
    ch_en[4] = 1'b1;
    sb.push_back('{4, 60, a4 + 1});
    expect_tick(100);

    // Asynchronous reset away from the clock edge clears everything.
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_slot",  int'(slot), 0);
    chk("midrst_tick",  int'(tick), 0);
    chk("midrst_waddr", int'(waddr), 0);
    #1;
    rst = 1'b0;
    step();
    chk("postrst_slot", int'(slot), 1);
    step();
    chk("postrst_slot2", int'(slot), 2);

`ifdef IKASCC_PERIOD_SEQ_TEST_EN
    // Period 0x123 seen as 3 under the 4-bit mask, 0x23 under 8-bit.
    test = 2'b10;
    wr(1, 'h123, 1'b1);
    wait_tick(1, 60);
    sb.push_back('{1, 20, 2});
    expect_tick(60);
    test = 2'b01;
    wait_tick(1, 60);
    sb.push_back('{1, 180, 4});
    expect_tick(250);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
